stack_cpu_core: RTL

- Parametrised successor to the fixed 16-bit/5-bit-address stack processor.
- A single stack-machine core with fetch, decode and execute control.
- Contains an internal operand stack of configurable depth and data width, plus overflow, underflow and illegal-opcode detection with error halt.
- Drives external synchronous ROM (program) and RAM (data) ports, each with 1-cycle read latency.

---
 rtl/stack_cpu_core.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/stack_cpu_core.sv
// stack_cpu_core: parametrised stack-machine core with FETCH/DECODE/EXEC/MEM
// control, an internal operand stack, fault detection (overflow, underflow,
// illegal opcode) with error halt, and synchronous ROM/RAM ports (1-cycle read).
// Optional feature macro: STACK_CPU_SINGLE_STEP_EN adds step_mode/step inputs.
// Handshake: rom_en/ram_en are read strobes whose data is valid the following
// cycle; ram_wren is a single-cycle write strobe qualified by ram_addr/ram_wdata.
module stack_cpu_core #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 5,
  parameter int OPC_W       = 5,
  parameter int STACK_DEPTH = 16
) (
  input  logic                               clock,
  input  logic                               reset,
`ifdef STACK_CPU_SINGLE_STEP_EN
  input  logic                               step_mode,
  input  logic                               step,
`endif
  output logic [ADDR_W-1:0]                  rom_addr,
  output logic                               rom_en,
  input  logic [OPC_W+ADDR_W-1:0]            rom_q,
  output logic [ADDR_W-1:0]                  ram_addr,
  output logic                               ram_en,
  output logic                               ram_wren,
  output logic [DATA_W-1:0]                  ram_wdata,
  input  logic [DATA_W-1:0]                  ram_q,
  output logic                               halted,
  output logic                               error,
  output logic [1:0]                         err_code,
  output logic [ADDR_W-1:0]                  pc_out,
  output logic [DATA_W-1:0]                  tos,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   sp_out,
  output logic [2:0]                         state_dbg
);

  localparam int SP_W  = $clog2(STACK_DEPTH+1);
  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam int INS_W = OPC_W + ADDR_W;

  localparam logic [OPC_W-1:0] OP_NOP    = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_PUSH   = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_PUSH_I = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_PUSH_T = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_POP    = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_ADD    = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_SUB    = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_MUL    = OPC_W'(7);
  localparam logic [OPC_W-1:0] OP_AND    = OPC_W'(8);
  localparam logic [OPC_W-1:0] OP_OR     = OPC_W'(9);
  localparam logic [OPC_W-1:0] OP_XOR    = OPC_W'(10);
  localparam logic [OPC_W-1:0] OP_NOT    = OPC_W'(11);
  localparam logic [OPC_W-1:0] OP_GOTO   = OPC_W'(12);
  localparam logic [OPC_W-1:0] OP_IF_EQ  = OPC_W'(13);
  localparam logic [OPC_W-1:0] OP_IF_GT  = OPC_W'(14);
  localparam logic [OPC_W-1:0] OP_IF_LT  = OPC_W'(15);
  localparam logic [OPC_W-1:0] OP_HALT   = OPC_W'(31);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t                   state, next_state;
  logic [ADDR_W-1:0]        pc;
  logic [SP_W-1:0]          sp;
  logic [INS_W-1:0]         ir;
  logic [DATA_W-1:0]        stack [STACK_DEPTH];
  logic [1:0]               fault;
  logic                     go;
  logic [OPC_W-1:0]         dec_op, ir_op;
  logic [ADDR_W-1:0]        ir_k;
  logic [IDX_W-1:0]         push_idx, top_idx, nos_idx;
  logic [DATA_W-1:0]        nos, alu;
  logic                     take;

  assign dec_op   = rom_q[INS_W-1 -: OPC_W];
  assign ir_op    = ir[INS_W-1 -: OPC_W];
  assign ir_k     = ir[ADDR_W-1:0];
  assign push_idx = IDX_W'(sp);
  assign top_idx  = IDX_W'(sp - SP_W'(1));
  assign nos_idx  = IDX_W'(sp - SP_W'(2));
  assign tos      = (sp == '0) ? '0 : stack[top_idx];
  assign nos      = stack[nos_idx];

  assign rom_addr  = pc;
  assign pc_out    = pc;
  assign sp_out    = sp;
  assign halted    = (state == S_HALT);
  assign state_dbg = state;

`ifdef STACK_CPU_SINGLE_STEP_EN
  assign go = !step_mode || step;
`else
  assign go = 1'b1;
`endif

  // Fault classification of the freshly fetched instruction (used in DECODE)
  always_comb begin
    logic [1:0] need;
    logic       pushes;
    logic       legal;
    need   = 2'd0;
    pushes = 1'b0;
    legal  = 1'b1;
    fault  = 2'd0;
    case (dec_op)
      OP_NOP, OP_GOTO, OP_HALT: ;
      OP_PUSH, OP_PUSH_I:       pushes = 1'b1;
      OP_PUSH_T:                begin pushes = 1'b1; need = 2'd1; end
      OP_POP, OP_NOT:           need = 2'd1;
      OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR,
      OP_IF_EQ, OP_IF_GT, OP_IF_LT: need = 2'd2;
      default:                  legal = 1'b0;
    endcase
    if (!legal)                                     fault = 2'd3;
    else if (sp < SP_W'(need))                      fault = 2'd2;
    else if (pushes && sp == SP_W'(STACK_DEPTH))    fault = 2'd1;
  end

  // ALU result (a = next-of-stack, b = top) and branch condition
  always_comb begin
    alu  = '0;
    take = 1'b0;
    case (ir_op)
      OP_ADD:   alu = nos + tos;
      OP_SUB:   alu = nos - tos;
      OP_MUL:   alu = nos * tos;
      OP_AND:   alu = nos & tos;
      OP_OR:    alu = nos | tos;
      OP_XOR:   alu = nos ^ tos;
      OP_IF_EQ: take = (nos == tos);
      OP_IF_GT: take = (nos > tos);
      OP_IF_LT: take = (nos < tos);
      default:  ;
    endcase
  end

  // Next-state and memory strobes; rom_en is gated by reset so it reads 0 in reset
  always_comb begin
    next_state = state;
    rom_en     = 1'b0;
    ram_en     = 1'b0;
    ram_wren   = 1'b0;
    ram_addr   = '0;
    ram_wdata  = '0;
    case (state)
      S_FETCH: begin
        rom_en = go && reset;
        if (go) next_state = S_DECODE;
      end
      S_DECODE: next_state = (fault != 2'd0) ? S_HALT : S_EXEC;
      S_EXEC: begin
        next_state = S_FETCH;
        case (ir_op)
          OP_PUSH: begin
            ram_en     = 1'b1;
            ram_addr   = ir_k;
            next_state = S_MEM;
          end
          OP_POP: begin
            ram_wren  = 1'b1;
            ram_addr  = ir_k;
            ram_wdata = tos;
          end
          OP_HALT: next_state = S_HALT;
          default: ;
        endcase
      end
      S_MEM:   next_state = S_FETCH;
      S_HALT:  next_state = S_HALT;
      default: next_state = S_FETCH;
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= next_state;
  end

  // Datapath: IR latch, fault capture, stack/sp/pc updates
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc       <= '0;
      sp       <= '0;
      ir       <= '0;
      error    <= 1'b0;
      err_code <= 2'd0;
      for (int i = 0; i < STACK_DEPTH; i++) stack[i] <= '0;
    end else begin
      case (state)
        S_DECODE: begin
          if (fault != 2'd0) begin
            error    <= 1'b1;
            err_code <= fault;
          end else begin
            ir <= rom_q;
          end
        end
        S_EXEC: begin
          case (ir_op)
            OP_PUSH: ;
            OP_HALT: ;
            OP_PUSH_I: begin
              stack[push_idx] <= DATA_W'(ir_k);
              sp <= sp + SP_W'(1);
              pc <= pc + ADDR_W'(1);
            end
            OP_PUSH_T: begin
              stack[push_idx] <= tos;
              sp <= sp + SP_W'(1);
              pc <= pc + ADDR_W'(1);
            end
            OP_POP: begin
              sp <= sp - SP_W'(1);
              pc <= pc + ADDR_W'(1);
            end
            OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR: begin
              stack[nos_idx] <= alu;
              sp <= sp - SP_W'(1);
              pc <= pc + ADDR_W'(1);
            end
            OP_NOT: begin
              stack[top_idx] <= ~tos;
              pc <= pc + ADDR_W'(1);
            end
            OP_GOTO: pc <= ir_k;
            OP_IF_EQ, OP_IF_GT, OP_IF_LT: begin
              sp <= sp - SP_W'(2);
              pc <= take ? ir_k : pc + ADDR_W'(1);
            end
            default: pc <= pc + ADDR_W'(1);
          endcase
        end
        S_MEM: begin
          stack[push_idx] <= ram_q;
          sp <= sp + SP_W'(1);
          pc <= pc + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
